// File: rtl/vdic_serial_pkg.sv
// Shared constants, types and word helpers for the serial master.
// Word: flag, 8 payload bits MSB first, odd parity over flag+payload.
package vdic_serial_pkg;

  localparam int WORD_BITS = 10;
  localparam int RSP_BITS  = 3 * WORD_BITS;
  localparam int FRAME_MAX = 5 * WORD_BITS;

  localparam logic FLAG_CMD  = 1'b1;
  localparam logic FLAG_DATA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RSP,
    ST_RECV,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_FRAME   = 2'b11
  } rsp_err_e;

  // Parity bit that makes flag+payload+parity an odd count of ones.
  function automatic logic odd_parity(
    input logic [WORD_BITS-2:0] v
  );
    return ~^v;
  endfunction

  function automatic logic [WORD_BITS-1:0] mk_word(
    input logic       flag,
    input logic [7:0] payload
  );
    return {flag, payload, odd_parity({flag, payload})};
  endfunction

endpackage

// File: rtl/vdic_serial_master_if.sv
// Request/response handshake plus serial link of the serial master.
// master: the design side; slave: requester + serial responder side.
interface vdic_serial_master_if;
  import vdic_serial_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_data;
  logic [2:0]  req_len;

  logic        enable_n;
  logic        din;
  logic        dout;
  logic        dout_valid;

  logic        rsp_valid;
  logic [7:0]  rsp_status;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    input  req_valid, req_cmd, req_data, req_len,
    input  dout, dout_valid,
    output req_ready, enable_n, din,
    output rsp_valid, rsp_status, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_cmd, req_data, req_len,
    output dout, dout_valid,
    input  req_ready, enable_n, din,
    input  rsp_valid, rsp_status, rsp_data, rsp_err
  );

endinterface

// File: rtl/vdic_word_deser.sv
// Shifts in 30 qualified response bits (3 words), flags flag/parity errors.
// Ports: clk, rst, i_clr, i_vld, i_bit -> o_full, o_status, o_data, o_*_err.
module vdic_word_deser
  import vdic_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic        i_bit,
  output logic        o_full,
  output logic [7:0]  o_status,
  output logic [15:0] o_data,
  output logic        o_flag_err,
  output logic        o_par_err
);

  logic [RSP_BITS-1:0]  r_sh;
  logic [4:0]           r_cnt;
  logic                 r_flag_err;
  logic                 r_par_err;

  logic [WORD_BITS-1:0] w_word;
  logic                 w_wend;
  logic                 w_flag_exp;
  logic                 w_take;

  assign o_full = (r_cnt == 5'(RSP_BITS));
  assign w_take = i_vld && !o_full;
  assign w_word = {r_sh[WORD_BITS-2:0], i_bit};

  // Word boundary detect; first word carries the status flag.
  always_comb begin
    w_wend     = 1'b0;
    w_flag_exp = FLAG_DATA;
    unique case (1'b1)
      (r_cnt == 5'd9): begin
        w_wend     = 1'b1;
        w_flag_exp = FLAG_CMD;
      end
      (r_cnt == 5'd19),
      (r_cnt == 5'd29): w_wend = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sh       <= '0;
      r_cnt      <= '0;
      r_flag_err <= 1'b0;
      r_par_err  <= 1'b0;
    end else if (w_take) begin
      r_sh  <= {r_sh[RSP_BITS-2:0], i_bit};
      r_cnt <= r_cnt + 5'd1;
      if (w_wend && (w_word[9] != w_flag_exp))
        r_flag_err <= 1'b1;
      if (w_wend && (odd_parity(w_word[9:1]) != w_word[0]))
        r_par_err <= 1'b1;
    end
  end

  assign o_status   = r_sh[28:21];
  assign o_data     = {r_sh[18:11], r_sh[8:1]};
  assign o_flag_err = r_flag_err;
  assign o_par_err  = r_par_err;

endmodule

// File: rtl/vdic_serial_master.sv
// Serial command master: sends data words + cmd word, collects 3-word reply.
// Ports: clk, rst, bus (master modport: req/rsp handshake and serial link).
module vdic_serial_master
  import vdic_serial_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
)
(
  input  logic                   clk,
  input  logic                   rst,
  vdic_serial_master_if.master   bus
);

  localparam int TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_e               r_state;
  logic                 r_bad;
  logic                 r_enable_n;
  logic                 r_din;
  logic [FRAME_MAX-1:0] r_sh;
  logic [5:0]           r_cnt;
  logic [TW-1:0]        r_to;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_status;
  logic [15:0]          r_rsp_data;
  rsp_err_e             r_rsp_err;

  logic                 w_len_ok;
  logic [5:0]           w_nbits;
  logic [FRAME_MAX-1:0] w_frame;
  logic                 w_accept;
  logic                 w_bit_vld;
  logic                 w_full;
  logic [7:0]           w_status;
  logic [15:0]          w_data;
  logic                 w_flag_err;
  logic                 w_par_err;
  rsp_err_e             w_rx_err;

  assign w_len_ok = (bus.req_len != 3'd0) && (bus.req_len <= 3'd4);
  assign w_nbits  = 6'(10 * (int'(bus.req_len) + 1) - 1);
  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

  // Left-aligned frame: data bytes from [31:24] down, then the cmd word.
  always_comb begin
    w_frame = {mk_word(FLAG_CMD, bus.req_cmd), 40'd0}
              >> (10 * int'(bus.req_len));
    for (int i = 0; i < 4; i++) begin
      if (i < int'(bus.req_len))
        w_frame[49-10*i -: 10] =
          mk_word(FLAG_DATA, bus.req_data[31-8*i -: 8]);
    end
  end

  assign w_bit_vld = bus.dout_valid &&
    ((r_state == ST_WAIT_RSP) || (r_state == ST_RECV));

  vdic_word_deser u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_vld      (w_bit_vld),
    .i_bit      (bus.dout),
    .o_full     (w_full),
    .o_status   (w_status),
    .o_data     (w_data),
    .o_flag_err (w_flag_err),
    .o_par_err  (w_par_err)
  );

  // A framing fault outranks a parity fault.
  always_comb begin
    w_rx_err = ERR_OK;
    if (w_flag_err)
      w_rx_err = ERR_FRAME;
    else if (w_par_err)
      w_rx_err = ERR_PARITY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bad        <= 1'b0;
      r_enable_n   <= 1'b1;
      r_din        <= 1'b0;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_to         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= ERR_OK;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_state <= ST_SEND;
            r_bad   <= !w_len_ok;
            if (w_len_ok) begin
              r_enable_n <= 1'b0;
              r_din      <= w_frame[FRAME_MAX-1];
              r_sh       <= {w_frame[FRAME_MAX-2:0], 1'b0};
              r_cnt      <= w_nbits;
            end
          end
        end
        ST_SEND: begin
          // Illegal length spends this cycle idle, then reports.
          if (r_bad) begin
            r_state      <= ST_DONE;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= ERR_FRAME;
            r_rsp_status <= '0;
            r_rsp_data   <= '0;
          end else if (r_cnt == 6'd0) begin
            r_enable_n <= 1'b1;
            r_din      <= 1'b0;
            r_to       <= '0;
            r_state    <= ST_WAIT_RSP;
          end else begin
            r_din <= r_sh[FRAME_MAX-1];
            r_sh  <= {r_sh[FRAME_MAX-2:0], 1'b0};
            r_cnt <= r_cnt - 6'd1;
          end
        end
        ST_WAIT_RSP,
        ST_RECV: begin
          if (w_full) begin
            r_state      <= ST_DONE;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= w_status;
            r_rsp_data   <= w_data;
            r_rsp_err    <= w_rx_err;
          end else if (bus.dout_valid) begin
            r_to    <= '0;
            r_state <= ST_RECV;
          end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state      <= ST_DONE;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= ERR_TIMEOUT;
            r_rsp_status <= '0;
            r_rsp_data   <= '0;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.enable_n   = r_enable_n;
  assign bus.din        = r_din;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_vdic_serial_master.sv
// Self-checking bench for vdic_serial_master.
// Directed spec cases plus randomized transactions against a word model.
module tb_vdic_serial_master;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vdic_serial_master_if bus();

  vdic_serial_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] word(input bit flag,
                                      input logic [7:0] p);
    bit par;
    par = ($countones({flag, p}) % 2) == 0;
    return {flag, p, par};
  endfunction

  function automatic void model_rsp(input  logic [29:0] r,
                                    output logic [7:0]  st,
                                    output logic [15:0] d,
                                    output logic [1:0]  e);
    logic [9:0] w [3];
    bit ferr;
    bit perr;
    ferr = 0;
    perr = 0;
    for (int i = 0; i < 3; i++) begin
      w[i] = r[29-10*i -: 10];
      if (w[i][9] != (i == 0)) ferr = 1;
      if ($countones(w[i]) % 2 == 0) perr = 1;
    end
    st = w[0][8:1];
    d  = {w[1][8:1], w[2][8:1]};
    e  = ferr ? 2'd3 : (perr ? 2'd1 : 2'd0);
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(n < 100), 64'd1);
  endtask

  task automatic issue(input logic [7:0] cmd,
                       input logic [31:0] data,
                       input logic [2:0] len);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_data  = data;
    bus.req_len   = len;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'($urandom);
    bus.req_data  = $urandom;
    bus.req_len   = 3'($urandom);
  endtask

  task automatic run_txn(input logic [7:0] cmd,
                         input logic [31:0] data,
                         input logic [2:0] len,
                         input logic [29:0] rsp,
                         input bit no_rsp,
                         input string tag);
    logic [49:0] exp_f, obs_f;
    logic [7:0]  e_st;
    logic [15:0] e_d;
    logic [1:0]  e_e;
    int nb, en_bad, pos, c;
    bit got;
    exp_f = '0;
    pos = 49;
    for (int i = 0; i < int'(len); i++) begin
      exp_f[pos -: 10] = word(0, 8'(data >> (24 - 8 * i)));
      pos -= 10;
    end
    exp_f[pos -: 10] = word(1, cmd);
    nb = (int'(len) + 1) * 10;
    if (no_rsp) begin
      e_st = 0; e_d = 0; e_e = 2'd2;
    end else begin
      model_rsp(rsp, e_st, e_d, e_e);
    end
    wait_ready(tag);
    issue(cmd, data, len);
    obs_f = '0;
    en_bad = 0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      obs_f[49-i] = bus.din;
      if (bus.enable_n !== 1'b0) en_bad++;
      bus.dout_valid = 1'($urandom);
      bus.dout       = 1'($urandom);
    end
    @(negedge clk);
    bus.dout_valid = 1'b0;
    check({tag, "_frame"}, 64'(obs_f), 64'(exp_f));
    check({tag, "_en_low"}, 64'(en_bad), 64'd0);
    check({tag, "_en_rise"}, 64'(bus.enable_n), 64'd1);
    check({tag, "_din_idle"}, 64'(bus.din), 64'd0);
    if (!no_rsp) begin
      for (int b = 0; b < 30; b++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          bus.dout_valid = 1'b0;
          bus.dout = 1'($urandom);
          @(negedge clk);
        end
        bus.dout_valid = 1'b1;
        bus.dout = rsp[29-b];
        @(negedge clk);
      end
      bus.dout_valid = 1'b0;
    end
    c = 0;
    got = 0;
    while (!got && c < TO + 200) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1;
      end else begin
        if (!no_rsp) begin
          bus.dout_valid = 1'($urandom);
          bus.dout = 1'($urandom);
        end
        @(negedge clk);
        c++;
      end
    end
    bus.dout_valid = 1'b0;
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    if (no_rsp)
      check({tag, "_to_delay"}, 64'(c), 64'(TO));
    check({tag, "_status"}, 64'(bus.rsp_status), 64'(e_st));
    check({tag, "_data"}, 64'(bus.rsp_data), 64'(e_d));
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(e_e));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_hold"}, 64'(bus.rsp_data), 64'(e_d));
    check({tag, "_idle"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic run_bad(input logic [2:0] len, input string tag);
    wait_ready(tag);
    issue(8'($urandom), $urandom, len);
    @(negedge clk);
    check({tag, "_c1_vld"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_c1_en"}, 64'(bus.enable_n), 64'd1);
    @(negedge clk);
    check({tag, "_c2_vld"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_c2_err"}, 64'(bus.rsp_err), 64'd3);
    check({tag, "_c2_en"}, 64'(bus.enable_n), 64'd1);
    @(negedge clk);
    check({tag, "_c3_vld"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  w0, w1, w2;
    logic [29:0] good, r;
    logic [2:0]  len;
    int n_vld, n_en;

    bus.req_valid  = 1'b1;
    bus.req_cmd    = 8'h5A;
    bus.req_data   = 32'hDEADBEEF;
    bus.req_len    = 3'd2;
    bus.dout       = 1'b0;
    bus.dout_valid = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_en", 64'(bus.enable_n), 64'd1);
    check("rst_din", 64'(bus.din), 64'd0);
    check("rst_vld", 64'(bus.rsp_valid), 64'd0);
    check("rst_status", 64'(bus.rsp_status), 64'd0);
    check("rst_data", 64'(bus.rsp_data), 64'd0);
    check("rst_err", 64'(bus.rsp_err), 64'd0);
    bus.req_valid  = 1'b0;
    bus.dout_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.req_ready), 64'd1);

    good = {10'b1_00000000_0, 10'b0_00010010_1, 10'b0_00110100_0};
    run_txn(8'h01, 32'hA53C0000, 3'd2, good, 0, "d_ok");
    run_txn(8'h01, 32'hA53C0000, 3'd2, good ^ (30'd1 << 10), 0, "d_par");
    r = {10'b0_00000000_0, good[19:0]};
    run_txn(8'h01, 32'hA53C0000, 3'd2, r, 0, "d_frame");
    run_txn(8'h7E, 32'h12345678, 3'd3, '0, 1, "d_to");

    wait_ready("rst_mid");
    issue(8'hC3, $urandom, 3'd3);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_bit7_en", 64'(bus.enable_n), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_en", 64'(bus.enable_n), 64'd1);
    check("rst_mid_din", 64'(bus.din), 64'd0);
    check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    n_vld = 0;
    n_en  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) n_vld++;
      if (bus.enable_n !== 1'b1) n_en++;
    end
    check("rst_mid_no_rsp", 64'(n_vld), 64'd0);
    check("rst_mid_no_tx", 64'(n_en), 64'd0);

    run_bad(3'd0, "bad0");
    run_bad(3'd5, "bad5");
    run_bad(3'd7, "bad7");

    for (int k = 0; k < 10; k++) begin
      len = (k == 0) ? 3'd1 :
            (k == 1) ? 3'd4 : 3'($urandom_range(1, 4));
      w0 = word(1, 8'($urandom));
      w1 = word(0, 8'($urandom));
      w2 = word(0, 8'($urandom));
      r  = {w0, w1, w2};
      case ($urandom_range(0, 3))
        1: r = r ^ (30'd1 << (10 * $urandom_range(0, 2)));
        2: r = r ^ (30'd1 << (10 * $urandom_range(0, 2) + 9));
        3: r = r ^ (30'd1 << $urandom_range(0, 29));
        default: ;
      endcase
      run_txn(8'($urandom), $urandom, len, r, 0,
              $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vdic_serial_master.md
VDIC_SERIAL_MASTER -- requirements
Module: vdic_serial_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles waiting for each response bit before abort.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block idle, request accepted when req_valid&&req_ready.
REQ-006 req_cmd  input  8  command byte.
REQ-007 req_data  input  32  operand bytes; byte order [31:24] sent first.
REQ-008 req_len  input  3  operand byte count, legal 1..4.
REQ-009 enable_n  output  1  serial frame strobe to DUT, low while bits are driven.
REQ-010 din  output  1  serial data to DUT.
REQ-011 dout  input  1  serial response data from DUT.
REQ-012 dout_valid  input  1  dout bit qualifier.
REQ-013 rsp_valid  output  1  one-cycle response pulse.
REQ-014 rsp_status  output  8  received status byte.
REQ-015 rsp_data  output  16  received result, first data word in [15:8].
REQ-016 rsp_err  output  2  00 ok, 01 parity, 10 timeout, 11 frame.

Function
REQ-017 Word format SHALL be 10 bits, MSB first: flag (1=cmd/status, 0=data), 8 payload bits MSB first, odd parity over flag+payload.
REQ-018 FSM states SHALL be IDLE, SEND, WAIT_RSP, RECV, DONE; req_ready=1 only in IDLE and rst low.
REQ-019 On accept with legal req_len, SEND SHALL begin next cycle: enable_n=0 and din=first bit, for exactly (req_len+1)*10 contiguous cycles: req_len data words then one cmd word.
REQ-020 Cycle after the last cmd bit, enable_n SHALL return to 1, din to 0, and state to WAIT_RSP.
REQ-021 Request inputs SHALL be registered at accept; changes afterwards have no effect.
REQ-022 WAIT_RSP/RECV SHALL shift dout in only on cycles with dout_valid=1; exactly 30 bits (status, data hi, data lo) complete a response.
REQ-023 Timeout counter SHALL reset on entry to WAIT_RSP and on each valid bit; reaching TIMEOUT_CYCLES SHALL go to DONE with rsp_err=10.
REQ-024 After 30 bits: flag mismatch (word0 flag!=1 or words1-2 flag!=0) gives 11; else any parity fail gives 01; else 00. Frame beats parity.
REQ-025 DONE SHALL last one cycle with rsp_valid=1; rsp_status/rsp_data hold captured values until next rsp_valid (zero on timeout); IDLE follows.
REQ-026 req_len 0 or 5..7 SHALL be accepted, no serial activity, rsp_valid with rsp_err=11 two cycles after accept.
REQ-027 dout_valid outside WAIT_RSP/RECV SHALL be ignored; bits beyond 30 are not captured.

Reset
REQ-028 While rst=1: state IDLE, enable_n=1, din=0, req_ready=0, rsp_valid=0, rsp_status=0, rsp_data=0, rsp_err=0, counters 0.
REQ-029 rst mid-operation SHALL abort next cycle with the values above; no rsp_valid for the aborted request.
REQ-030 req_ready SHALL be 1 the first cycle after rst deasserts.

Structure
REQ-031 Package vdic_serial_pkg SHALL hold WORD_BITS=10, flag constants, state enum, rsp_err enum and an odd-parity function.
REQ-032 Sub-module vdic_word_deser SHALL shift in qualified bits and flag per-word parity/flag errors; serializer stays in top.

Verification
REQ-033 req_len=2, req_data=0xA53C0000, req_cmd=0x01 -> enable_n low 30 cycles; din = 0_10100101_1, 0_00111100_1, 1_00000001_1.
REQ-034 Responder returns 1_00000000_0, 0_00010010_1, 0_00110100_0 with gaps -> rsp_status=0x00, rsp_data=0x1234, rsp_err=00.
REQ-035 Same response, word1 parity flipped -> rsp_err=01; word0 flag=0 plus bad parity -> rsp_err=11.
REQ-036 No dout_valid after frame -> rsp_valid with rsp_err=10 exactly TIMEOUT_CYCLES cycles after enable_n rises.
REQ-037 rst pulsed at SEND bit 7 -> enable_n=1 next cycle, no rsp_valid, req_ready=1 cycle after rst falls.
REQ-038 req_len=0 -> enable_n stays 1, rsp_err=11 two cycles after accept.
